// File: rtl/vib_sample_conditioner_if.sv
// Sample-stream and averaged-output bundle for vib_sample_conditioner.
//   master : upstream converter side (drives sample/offset/clr, receives averages)
//   slave  : conditioner side
//   s_valid/s_ch/s_data : time-multiplexed converter samples
//   clr                 : synchronous flush
//   ofs0..ofs3          : per-channel signed DC offsets (quasi-static)
//   ChN_Data/ChN_Data_en: averaged sample and its one-cycle strobe per channel
interface vib_sample_conditioner_if #(
  parameter int unsigned DATAWIDTH = 16
);
  logic                 s_valid;
  logic [1:0]           s_ch;
  logic [DATAWIDTH-1:0] s_data;
  logic                 clr;
  logic [DATAWIDTH-1:0] ofs0;
  logic [DATAWIDTH-1:0] ofs1;
  logic [DATAWIDTH-1:0] ofs2;
  logic [DATAWIDTH-1:0] ofs3;
  logic [DATAWIDTH-1:0] Ch0_Data;
  logic [DATAWIDTH-1:0] Ch1_Data;
  logic [DATAWIDTH-1:0] Ch2_Data;
  logic [DATAWIDTH-1:0] Ch3_Data;
  logic                 Ch0_Data_en;
  logic                 Ch1_Data_en;
  logic                 Ch2_Data_en;
  logic                 Ch3_Data_en;

  modport master (
    output s_valid, s_ch, s_data, clr, ofs0, ofs1, ofs2, ofs3,
    input  Ch0_Data, Ch1_Data, Ch2_Data, Ch3_Data,
    input  Ch0_Data_en, Ch1_Data_en, Ch2_Data_en, Ch3_Data_en
  );

  modport slave (
    input  s_valid, s_ch, s_data, clr, ofs0, ofs1, ofs2, ofs3,
    output Ch0_Data, Ch1_Data, Ch2_Data, Ch3_Data,
    output Ch0_Data_en, Ch1_Data_en, Ch2_Data_en, Ch3_Data_en
  );
endinterface

// File: rtl/vib_sample_conditioner.sv
// Per-converter vibration sample conditioner: subtracts a per-channel DC
// offset with saturation, then block-averages 2^AVG_LOG2 samples per channel
// and emits one averaged sample plus a one-cycle strobe per completed block.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : vib_sample_conditioner_if.slave (samples, offsets, clr, averaged outputs)
module vib_sample_conditioner #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned AVG_LOG2  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  vib_sample_conditioner_if.slave     bus
);

  localparam int unsigned DW  = DATAWIDTH;
  localparam int unsigned DW1 = DATAWIDTH + 1;
  localparam int unsigned AW  = DATAWIDTH + AVG_LOG2;
  localparam int unsigned CW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  // Stage 1 registers: offset-corrected, saturated sample
  logic                 s1_valid_d, s1_valid_q;
  logic [1:0]           s1_ch_d,    s1_ch_q;
  logic signed [DW-1:0] s1_data_d,  s1_data_q;

  // Stage 2 state: accumulators, counters, output registers
  logic signed [AW-1:0] acc_d  [4];
  logic signed [AW-1:0] acc_q  [4];
  logic [CW-1:0]        cnt_d  [4];
  logic [CW-1:0]        cnt_q  [4];
  logic signed [DW-1:0] data_d [4];
  logic signed [DW-1:0] data_q [4];
  logic [3:0]           en_d, en_q;

  logic signed [DW-1:0] ofs_sel;
  logic signed [DW:0]   diff;
  logic signed [AW-1:0] sum;

  // Stage 1: offset subtraction in DW+1 bits, clamp back to DW bits
  always_comb begin
    ofs_sel    = $signed(bus.ofs0);
    s1_valid_d = bus.s_valid & ~bus.clr;
    s1_ch_d    = bus.s_ch;
    case (bus.s_ch)
      2'd0: ofs_sel = $signed(bus.ofs0);
      2'd1: ofs_sel = $signed(bus.ofs1);
      2'd2: ofs_sel = $signed(bus.ofs2);
      2'd3: ofs_sel = $signed(bus.ofs3);
      default: ofs_sel = $signed(bus.ofs0);
    endcase
    diff = DW1'($signed(bus.s_data)) - DW1'(ofs_sel);
    // Top two bits disagree only when the result left the DW-bit range
    if (diff[DW] != diff[DW-1]) begin
      s1_data_d = diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      s1_data_d = diff[DW-1:0];
    end
  end

  // Stage 2: accumulate; on the last sample of a block output the floor average
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    en_d   = '0;
    sum    = '0;
    if (bus.clr) begin
      for (int i = 0; i < 4; i++) begin
        acc_d[i] = '0;
        cnt_d[i] = '0;
      end
    end else if (s1_valid_q) begin
      sum = acc_q[s1_ch_q] + AW'(s1_data_q);
      if (cnt_q[s1_ch_q] == CNT_LAST) begin
        data_d[s1_ch_q] = DW'(sum >>> AVG_LOG2);
        en_d[s1_ch_q]   = 1'b1;
        acc_d[s1_ch_q]  = '0;
        cnt_d[s1_ch_q]  = '0;
      end else begin
        acc_d[s1_ch_q]  = sum;
        cnt_d[s1_ch_q]  = cnt_q[s1_ch_q] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_data_q  <= '0;
      en_q       <= '0;
      for (int i = 0; i < 4; i++) begin
        acc_q[i]  <= '0;
        cnt_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_ch_q    <= s1_ch_d;
      s1_data_q  <= s1_data_d;
      en_q       <= en_d;
      for (int i = 0; i < 4; i++) begin
        acc_q[i]  <= acc_d[i];
        cnt_q[i]  <= cnt_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign bus.Ch0_Data    = data_q[0];
  assign bus.Ch1_Data    = data_q[1];
  assign bus.Ch2_Data    = data_q[2];
  assign bus.Ch3_Data    = data_q[3];
  assign bus.Ch0_Data_en = en_q[0];
  assign bus.Ch1_Data_en = en_q[1];
  assign bus.Ch2_Data_en = en_q[2];
  assign bus.Ch3_Data_en = en_q[3];

endmodule

// File: tb/tb_vib_sample_conditioner.sv
// Directed bench for vib_sample_conditioner: one instance with 4-sample
// averaging and one pass-through instance (AVG_LOG2=0).
module tb_vib_sample_conditioner;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   en_cnt [4];
  int   base   [4];

  vib_sample_conditioner_if #(.DATAWIDTH(16)) bus_a ();
  vib_sample_conditioner_if #(.DATAWIDTH(16)) bus_b ();

  vib_sample_conditioner #(.DATAWIDTH(16), .AVG_LOG2(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  vib_sample_conditioner #(.DATAWIDTH(16), .AVG_LOG2(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe counter for the averaging instance
  always @(posedge clk) begin
    if (bus_a.Ch0_Data_en === 1'b1) en_cnt[0]++;
    if (bus_a.Ch1_Data_en === 1'b1) en_cnt[1]++;
    if (bus_a.Ch2_Data_en === 1'b1) en_cnt[2]++;
    if (bus_a.Ch3_Data_en === 1'b1) en_cnt[3]++;
  end

  function automatic logic [3:0] en_a();
    return {bus_a.Ch3_Data_en, bus_a.Ch2_Data_en, bus_a.Ch1_Data_en, bus_a.Ch0_Data_en};
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_a(input logic v, input logic [1:0] ch, input int d);
    bus_a.s_valid = v;
    bus_a.s_ch    = ch;
    bus_a.s_data  = 16'(d);
  endtask

  task automatic put_b(input logic v, input logic [1:0] ch, input int d);
    bus_b.s_valid = v;
    bus_b.s_ch    = ch;
    bus_b.s_data  = 16'(d);
  endtask

  task automatic snap();
    for (int i = 0; i < 4; i++) base[i] = en_cnt[i];
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 4; i++) begin
      en_cnt[i] = 0;
      base[i]   = 0;
    end
    rst = 1'b0;
    put_a(1'b0, 2'd0, 0);
    put_b(1'b0, 2'd0, 0);
    bus_a.clr = 1'b0; bus_b.clr = 1'b0;
    bus_a.ofs0 = '0; bus_a.ofs1 = '0; bus_a.ofs2 = '0; bus_a.ofs3 = '0;
    bus_b.ofs0 = '0; bus_b.ofs1 = '0; bus_b.ofs2 = '0; bus_b.ofs3 = '0;

    // Reset state
    #3 rst = 1'b1;
    #1;
    chk("rst_ch0", $signed(bus_a.Ch0_Data), 0);
    chk("rst_ch1", $signed(bus_a.Ch1_Data), 0);
    chk("rst_ch2", $signed(bus_a.Ch2_Data), 0);
    chk("rst_ch3", $signed(bus_a.Ch3_Data), 0);
    chk("rst_en",  32'(en_a()), 0);
    chk("rst_b",   $signed(bus_b.Ch0_Data), 0);
    #18 rst = 1'b0;
    tick();

    // Basic average: 100,200,300,400 -> 250
    snap();
    put_a(1'b1, 2'd0, 100); tick();
    put_a(1'b1, 2'd0, 200); tick();
    put_a(1'b1, 2'd0, 300); tick();
    put_a(1'b1, 2'd0, 400); tick();
    put_a(1'b0, 2'd0, 0);
    chk("avg0_early_en", 32'(en_a()), 0);
    tick();
    chk("avg0_en",   32'(en_a()), 1);
    chk("avg0_data", $signed(bus_a.Ch0_Data), 250);
    tick();
    chk("avg0_en_off", 32'(en_a()), 0);
    chk("avg0_cnt0", en_cnt[0] - base[0], 1);
    chk("avg0_cnt_other", (en_cnt[1] - base[1]) + (en_cnt[2] - base[2]) + (en_cnt[3] - base[3]), 0);

    // Negative floor: sum -7 -> -2
    put_a(1'b1, 2'd1, -1); tick();
    put_a(1'b1, 2'd1, -2); tick();
    put_a(1'b1, 2'd1, -2); tick();
    put_a(1'b1, 2'd1, -2); tick();
    put_a(1'b0, 2'd0, 0);  tick();
    chk("neg_en",   32'(en_a()), 2);
    chk("neg_data", $signed(bus_a.Ch1_Data), -2);

    // Saturation low and high
    bus_a.ofs2 = 16'(1);
    for (int i = 0; i < 4; i++) begin
      put_a(1'b1, 2'd2, -32768); tick();
    end
    put_a(1'b0, 2'd0, 0); tick();
    chk("satlo_en",   32'(en_a()), 4);
    chk("satlo_data", $signed(bus_a.Ch2_Data), -32768);
    bus_a.ofs2 = 16'(-1);
    for (int i = 0; i < 4; i++) begin
      put_a(1'b1, 2'd2, 32767); tick();
    end
    put_a(1'b0, 2'd0, 0); tick();
    chk("sathi_en",   32'(en_a()), 4);
    chk("sathi_data", $signed(bus_a.Ch2_Data), 32767);

    // Interleaved ch0/ch3 with ofs3=-4
    bus_a.ofs3 = 16'(-4);
    tick();
    snap();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) put_a(1'b1, 2'd3, -20);
      else            put_a(1'b1, 2'd0, 10);
      tick();
    end
    put_a(1'b0, 2'd0, 0);
    chk("ilv_en0",   32'(en_a()), 1);
    chk("ilv_data0", $signed(bus_a.Ch0_Data), 10);
    tick();
    chk("ilv_en3",   32'(en_a()), 8);
    chk("ilv_data3", $signed(bus_a.Ch3_Data), -16);
    tick();
    chk("ilv_cnt0", en_cnt[0] - base[0], 1);
    chk("ilv_cnt3", en_cnt[3] - base[3], 1);
    chk("ilv_cnt12", (en_cnt[1] - base[1]) + (en_cnt[2] - base[2]), 0);

    // Flush: partial block and same-cycle sample discarded
    snap();
    put_a(1'b1, 2'd0, 50); tick();
    put_a(1'b1, 2'd0, 60); tick();
    bus_a.clr = 1'b1;
    put_a(1'b1, 2'd0, 999); tick();
    bus_a.clr = 1'b0;
    chk("clr_hold", $signed(bus_a.Ch0_Data), 10);
    chk("clr_en",   32'(en_a()), 0);
    for (int i = 0; i < 4; i++) begin
      put_a(1'b1, 2'd0, 8); tick();
    end
    put_a(1'b0, 2'd0, 0); tick();
    chk("clr_avg_en",   32'(en_a()), 1);
    chk("clr_avg_data", $signed(bus_a.Ch0_Data), 8);
    tick();
    chk("clr_cnt0", en_cnt[0] - base[0], 1);

    // Async reset mid-block
    put_a(1'b1, 2'd0, 100); tick();
    put_a(1'b1, 2'd0, 100); tick();
    put_a(1'b0, 2'd0, 0);
    #2 rst = 1'b1;
    #1;
    chk("mrst_ch0", $signed(bus_a.Ch0_Data), 0);
    chk("mrst_ch1", $signed(bus_a.Ch1_Data), 0);
    chk("mrst_ch2", $signed(bus_a.Ch2_Data), 0);
    chk("mrst_ch3", $signed(bus_a.Ch3_Data), 0);
    chk("mrst_en",  32'(en_a()), 0);
    #2 rst = 1'b0;
    tick();
    put_a(1'b1, 2'd0, 20); tick();
    put_a(1'b1, 2'd0, 24); tick();
    put_a(1'b1, 2'd0, 28); tick();
    put_a(1'b1, 2'd0, 32); tick();
    put_a(1'b0, 2'd0, 0);
    chk("mrst_early_en", 32'(en_a()), 0);
    tick();
    chk("mrst_avg_en",   32'(en_a()), 1);
    chk("mrst_avg_data", $signed(bus_a.Ch0_Data), 26);

    // Pass-through instance: 15 - 5 -> 10 every sample, two cycles later
    bus_b.ofs0 = 16'(5);
    tick();
    for (int j = 0; j < 6; j++) begin
      put_b(j < 4, 2'd0, 15);
      tick();
      chk($sformatf("pt_en_%0d", j), 32'(bus_b.Ch0_Data_en), (j >= 1 && j <= 4) ? 1 : 0);
      if (j >= 1) chk($sformatf("pt_data_%0d", j), $signed(bus_b.Ch0_Data), 10);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vib_sample_conditioner.md
Name: vib_sample_conditioner

Overview:
- Upstream conditioning stage for the vibration detect path, one instance per ADS converter.
- Accepts the converter's time-multiplexed sample stream (channel id + data + valid) and subtracts a per-channel DC offset with saturation.
- Block-averages 2^AVG_LOG2 samples per channel and emits one averaged sample per channel per block on the Ch0..Ch3 data/enable pairs.
- Those pairs feed the Ch*_Data_ads* / Ch*_Data_en_ads* inputs of the peak search stage.

Parameters:
- DATAWIDTH, 16, sample width; all data is two's complement.
- AVG_LOG2, 2, log2 of the averaging block length per channel; legal range 0..6.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- s_valid  in  1  input sample strobe, one sample per high cycle
- s_ch  in  2  channel id of s_data
- s_data  in  DATAWIDTH  raw signed sample
- clr  in  1  synchronous flush of pipeline, accumulators and counters
- ofs0..ofs3  in  DATAWIDTH each  signed offset for channels 0..3; quasi-static
- Ch0_Data..Ch3_Data  out  DATAWIDTH each  averaged signed sample
- Ch0_Data_en..Ch3_Data_en  out  1 each  one-cycle strobe, Chn_Data valid

Behaviour:
- Reset (async assert): all Chn_Data = 0, all Chn_Data_en = 0, stage-1 register cleared, accumulators = 0, per-channel counters = 0.
- Reset release is used synchronously.
- Stage 1 (edge ending cycle T, where s_valid=1):
  - d = s_data - ofs[s_ch], computed in DATAWIDTH+1 bits.
  - d is saturated to [-2^(DATAWIDTH-1), 2^(DATAWIDTH-1)-1].
  - d is registered together with its channel id and a valid bit.
- Stage 2 (edge ending cycle T+1):
  - acc[ch] += d; acc width is DATAWIDTH+AVG_LOG2, so it never overflows.
  - cnt[ch] increments.
  - When cnt[ch] reaches 2^AVG_LOG2-1 before the add:
    - Chn_Data is loaded with (acc[ch]+d) >>> AVG_LOG2, an arithmetic shift, i.e. floor.
    - Chn_Data_en = 1.
    - acc[ch] and cnt[ch] are cleared.
- Latency: sample presented in cycle T; the completing average and its strobe are visible in cycle T+2.
- Chn_Data_en is high exactly one cycle. Chn_Data holds its value until the next completion.
- At most one Chn_Data_en is high per cycle, since only one sample is accepted per cycle.
- Back-to-back valid on any mix of channels is supported at full rate; the block has no backpressure.
- Per-channel accumulators are independent; interleaving order is arbitrary.
- AVG_LOG2=0: every sample is output directly; output equals the saturated d.
- clr=1:
  - Sync clear of stage-1 valid, all acc and all cnt.
  - Chn_Data_en forced 0 that cycle.
  - Chn_Data retains its last value.
  - A sample presented with s_valid in the same cycle as clr is discarded.
  - A sample already in stage 1 is discarded.
- Reset mid-block discards partial sums; output registers return to 0.
- Offset changes take effect on the next sample entering stage 1; partially accumulated blocks are not corrected.

Test Plan:
- AVG_LOG2=2, ofs=0, ch0 samples 100, 200, 300, 400 on consecutive cycles -> Ch0_Data=250 with a single Ch0_Data_en pulse 2 cycles after the 400 sample; no other en.
- ch1 samples -1, -2, -2, -2, ofs1=0 -> Ch1_Data=-2 (sum -7 floor-shifted), one strobe.
- Saturation, ofs2=+1:
  - s_data=-32768 x4 -> Ch2_Data=-32768.
  - With ofs2=-1: s_data=32767 x4 -> Ch2_Data=32767.
- Interleaved stream ch0, ch3, ch0, ch3, ... (8 samples; ch0=10, ch3=-20, ofs3=-4) -> Ch0_Data=10 and Ch3_Data=-16, strobes on different cycles, none on ch1/ch2.
- Flush and reset:
  - Two ch0 samples, then clr asserted with a valid sample, then four samples of 8 -> exactly one strobe, Ch0_Data=8.
  - Repeating with async rst mid-block -> all outputs 0 immediately; the next full block averages correctly.
- AVG_LOG2=0, ofs0=5, s_data=15 -> Ch0_Data=10 with a strobe 2 cycles later on every sample at full rate.
